// File: rtl/fortune_pipe.sv
// fortune_pipe -- two-stage pipelined fortune-teller pattern decoder.
//
// Takes raw pattern codes over a valid/ready handshake and turns each one
// into a message index (group * 10 + BCD digit). Results leave in order
// over a valid/ready output. A counter tracks how many results were delivered.
//
// Pattern layout: digit D = pattern[4:1], group G = {pattern[PAT_W-1:5], pattern[0]}.
// A digit above 9 gives index 0 with out_invalid set.
//
// Optional build macro:
//   FORTUNE_NOREPEAT_EN - a valid index that equals the previous valid index
//                         loaded into the output register is bumped to
//                         index+1, wrapping NUM_MSG-1 to 0.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   in_valid/in_ready input handshake, in_pattern = raw code (PAT_W)
//   out_valid/out_ready output handshake
//   out_message       decoded index (MSG_W)
//   out_invalid       result came from an illegal digit
//   msg_count         output transfers, wraps modulo 2^CNT_W
module fortune_pipe #(
    parameter int PAT_W = 6,
    parameter int MSG_W = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAT_W-1:0] in_pattern,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out_message,
    output logic             out_invalid,
    output logic [CNT_W-1:0] msg_count
);

    localparam int G_W     = PAT_W - 4;
    localparam int NUM_MSG = 10 * (2 ** G_W);
    localparam logic [MSG_W:0] TEN = (MSG_W+1)'(10);

    // Handshake and pipeline control
    logic             s1_valid;
    logic [PAT_W-1:0] s1_pat;
    logic             in_xfer;
    logic             out_xfer;
    logic             s2_load;

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);

    // Stage 1: raw pattern capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_pat   <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_pat   <= in_pattern;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Decode, done one bit wider than the index and then truncated
    logic [G_W-1:0]   grp;
    logic [3:0]       dig;
    logic [MSG_W:0]   idx_wide;
    logic             idx_unused;
    logic             dec_invalid;
    logic [MSG_W-1:0] dec_msg;
    logic [MSG_W-1:0] fin_msg;

    assign grp         = {s1_pat[PAT_W-1:5], s1_pat[0]};
    assign dig         = s1_pat[4:1];
    assign idx_wide    = (MSG_W+1)'(grp) * TEN + (MSG_W+1)'(dig);
    assign idx_unused  = idx_wide[MSG_W];
    assign dec_invalid = (dig > 4'd9);
    assign dec_msg     = dec_invalid ? '0 : idx_wide[MSG_W-1:0];

`ifdef FORTUNE_NOREPEAT_EN
    localparam logic [MSG_W-1:0] LAST_MSG = MSG_W'(NUM_MSG - 1);

    logic             hist_valid;
    logic [MSG_W-1:0] hist;

    always_comb begin
        fin_msg = dec_msg;
        if (!dec_invalid && hist_valid && (dec_msg == hist))
            fin_msg = (dec_msg == LAST_MSG) ? '0 : dec_msg + MSG_W'(1);
    end

    // History follows the adjusted value. Illegal results leave it untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_valid <= 1'b0;
            hist       <= '0;
        end else if (s2_load && !dec_invalid) begin
            hist_valid <= 1'b1;
            hist       <= fin_msg;
        end
    end
`else
    assign fin_msg = dec_msg;
`endif

    // Stage 2: output register. It is held while it is stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid   <= 1'b0;
            out_message <= '0;
            out_invalid <= 1'b0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            out_message <= fin_msg;
            out_invalid <= dec_invalid;
        end else if (out_xfer) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       msg_count <= '0;
        else if (out_xfer) msg_count <= msg_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_fortune_pipe.sv
module tb_fortune_pipe;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_pattern;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_message;
    logic       out_invalid;
    logic [7:0] msg_count;

    int n_vec = 0;
    int n_err = 0;

    fortune_pipe #(.PAT_W(6), .MSG_W(7), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pattern(in_pattern),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_message(out_message), .out_invalid(out_invalid),
        .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    // Move one edge ahead, then wait 1 ns so signals have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; in_pattern = '0; out_ready = 1'b0;
        tick(); tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
        n_vec++; if (out_message !== 7'd0) begin n_err++; $display("FAIL reset_out_message got %0d want 0", out_message); end
        n_vec++; if (out_invalid !== 1'b0) begin n_err++; $display("FAIL reset_out_invalid got %0d want 0", out_invalid); end
        n_vec++; if (msg_count !== 8'd0) begin n_err++; $display("FAIL reset_msg_count got %0d want 0", msg_count); end
        resetn = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0d want 1", in_ready); end
        tick();
    endtask

    task automatic test_decode_sweep();
        logic [7:0] c0;
        c0 = msg_count;
        out_ready = 1'b1;
        in_valid = 1'b1; in_pattern = 6'b000010;
        tick();
        in_pattern = 6'b100001;
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid0 got %0d want 1", out_valid); end
        n_vec++; if (out_message !== 7'd1) begin n_err++; $display("FAIL sweep_msg0 got %0d want 1", out_message); end
        in_pattern = 6'b110011;
        tick();
        n_vec++; if (out_message !== 7'd30) begin n_err++; $display("FAIL sweep_msg1 got %0d want 30", out_message); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_message !== 7'd39 || out_valid !== 1'b1) begin n_err++; $display("FAIL sweep_msg2 got %0d (valid %0d) want 39", out_message, out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sweep_drain got %0d want 0", out_valid); end
        n_vec++; if (msg_count !== c0 + 8'd3) begin n_err++; $display("FAIL sweep_count got %0d want %0d", msg_count, c0 + 8'd3); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_pattern = 6'b010100;
        tick();
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL illegal_valid got %0d want 1", out_valid); end
        n_vec++; if (out_message !== 7'd0) begin n_err++; $display("FAIL illegal_msg got %0d want 0", out_message); end
        n_vec++; if (out_invalid !== 1'b1) begin n_err++; $display("FAIL illegal_flag got %0d want 1", out_invalid); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] c0;
        c0 = msg_count;
        out_ready = 1'b0;
        in_valid = 1'b1; in_pattern = 6'b000010;   // message 1
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_empty got %0d want 1", in_ready); end
        tick();
        in_pattern = 6'b000100;                    // message 2
        tick();
        in_pattern = 6'b000110;                    // message 3
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %0d want 0", in_ready); end
        n_vec++; if (out_message !== 7'd1) begin n_err++; $display("FAIL bp_hold0 got %0d want 1", out_message); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_message !== 7'd1) begin n_err++; $display("FAIL bp_hold1 got %0d (valid %0d) want 1", out_message, out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_still got %0d want 0", in_ready); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_message !== 7'd2) begin n_err++; $display("FAIL bp_seq2 got %0d want 2", out_message); end
        tick();
        n_vec++; if (out_message !== 7'd3 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_seq3 got %0d (valid %0d) want 3", out_message, out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %0d want 0", out_valid); end
        n_vec++; if (msg_count !== c0 + 8'd3) begin n_err++; $display("FAIL bp_count got %0d want %0d", msg_count, c0 + 8'd3); end
    endtask

    task automatic test_norepeat();
        logic [6:0] exp2;
`ifdef FORTUNE_NOREPEAT_EN
        exp2 = 7'd0;
`else
        exp2 = 7'd39;
`endif
        out_ready = 1'b1;
        in_valid = 1'b1; in_pattern = 6'b110011;
        tick();
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_message !== 7'd39) begin n_err++; $display("FAIL norep_first got %0d want 39", out_message); end
        tick();
        n_vec++; if (out_message !== exp2 || out_valid !== 1'b1) begin n_err++; $display("FAIL norep_second got %0d (valid %0d) want %0d", out_message, out_valid, exp2); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pattern = 6'b110011;
        tick();
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full got valid %0d ready %0d want 1 0", out_valid, in_ready); end
        #1 resetn = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got %0d want 0", out_valid); end
        n_vec++; if (msg_count !== 8'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", msg_count); end
        n_vec++; if (out_message !== 7'd0 || out_invalid !== 1'b0) begin n_err++; $display("FAIL mid_msg got %0d inv %0d want 0 0", out_message, out_invalid); end
        resetn = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got %0d want 1", in_ready); end
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; in_pattern = 6'b110011;
        tick();
        in_valid = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_message !== 7'd39) begin n_err++; $display("FAIL mid_after got %0d (valid %0d) want 39", out_message, out_valid); end
        tick();
        n_vec++; if (msg_count !== 8'd1) begin n_err++; $display("FAIL mid_after_count got %0d want 1", msg_count); end
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_illegal();
        test_backpressure();
        test_norepeat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fortune_pipe.md
# fortune_pipe

Parametrised, pipelined successor to the fortune-teller pattern decoder. Accepts raw pattern codes over a valid/ready handshake and decodes each to a message index: group × 10 + BCD digit. Flags illegal digits and delivers results in order over a valid/ready output, with a delivered-message counter. It sits between the pattern generator and the message display/ROM lookup.

## Interface
- PAT_W, 6, pattern width (≥6). Field layout:
  - bits [4:1]: BCD digit.
  - Group number G = {pattern[PAT_W-1:5], pattern[0]}, so pattern[0] is the group LSB.
  - NUM_MSG = 10·2^(PAT_W-4).
- MSG_W, 7, message index width. Must hold NUM_MSG-1 (6 bits at default); extra MSBs read 0.
- CNT_W, 8, width of the delivered-message counter.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  pattern offered.
- in_ready  out  1  block can accept a pattern this cycle.
- in_pattern  in  PAT_W  raw pattern code.
- out_valid  out  1  result held in output register.
- out_ready  in  1  downstream accepts result.
- out_message  out  MSG_W  decoded message index.
- out_invalid  out  1  result came from an illegal pattern (digit > 9).
- msg_count  out  CNT_W  count of output transfers, wraps modulo 2^CNT_W.

## Operation
- Two register stages:
  - S1 captures in_pattern on an input transfer (in_valid && in_ready).
  - S2 (output register) holds the decoded index.
- Decode:
  - digit D = pattern[4:1].
  - If D ≤ 9: index = G·10 + D, out_invalid = 0.
  - If D > 9: index = 0, out_invalid = 1.
  - Arithmetic is done at MSG_W+1 bits, then truncated to MSG_W.
- Advance rule:
  - S1 moves into S2 when S1 is valid and (!out_valid || out_ready).
  - in_ready = !s1_valid || !out_valid || out_ready (combinational).
- Backpressure:
  - While out_valid && !out_ready, out_message/out_invalid are held stable.
  - At most two patterns are in flight. Order is always preserved.
- Simultaneous events:
  - Output transfer, S1→S2 move and new input capture can all occur on the same edge. Full throughput is 1 pattern/cycle.
- msg_count increments on every out_valid && out_ready edge and wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous, any time, including mid-transfer):
  - Both stages are emptied.
  - out_valid = 0, out_message = 0, out_invalid = 0, msg_count = 0.
  - No-repeat history is cleared.
  - in_ready = 1 as soon as resetn is high.

## Timing
- Input accepted in cycle N appears with out_valid = 1 in cycle N+2, provided the output is not stalled.
- Back-to-back inputs with out_ready held high produce back-to-back outputs.
- in_ready falls only when S1 and S2 are both full and out_ready = 0.

## Configuration
- FORTUNE_NOREPEAT_EN defined:
  - When a valid (non-invalid) index equals the last valid index loaded into S2, it is replaced by index+1.
  - The replacement wraps: NUM_MSG-1 becomes 0.
  - The adjusted value becomes the new history.
  - Invalid results bypass the adjustment and do not update history.
  - History is empty after reset.
- Not defined: no adjustment; identical patterns yield identical indices. No history register exists.

## Test plan
- Reset check:
  - Stimulus: assert resetn=0.
  - Required: out_valid=0, out_message=0, out_invalid=0, msg_count=0; in_ready=1 after release.
- Decode sweep:
  - Stimulus: send 6'b000010, 6'b100001, 6'b110011 with out_ready=1.
  - Required: outputs 1, 30, 39 in consecutive cycles starting 2 cycles after the first accept; msg_count reaches 3.
- Illegal digit:
  - Stimulus: send 6'b010100 (D=10).
  - Required: out_message=0, out_invalid=1.
- Backpressure:
  - Stimulus: hold out_ready=0 and offer 3 patterns (1, 2, 3) back-to-back.
  - Required: in_ready drops after 2 accepts; out_message holds 1 stable.
  - Then raise out_ready: required sequence 1, 2, 3, and msg_count +3.
- No-repeat:
  - Stimulus: send 6'b110011 twice.
  - With FORTUNE_NOREPEAT_EN: 39, then 0 (wrap).
  - Without FORTUNE_NOREPEAT_EN: 39, 39.
- Reset mid-operation:
  - Stimulus: with both stages full and out_ready=0, pulse resetn low between clock edges.
  - Required: out_valid falls immediately; msg_count=0; the next pattern decodes without no-repeat adjustment.
